// File: rtl/prog_loader_if.sv
// prog_loader_if: stream-in and program-memory-write signals of the program loader.
interface prog_loader_if #(parameter int ADDR_W = 8);
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              pm_we;
  logic [ADDR_W-1:0] pm_addr;
  logic [15:0]       pm_wdata;
  logic              core_hold;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_count;
  modport master (
    output start, in_data, in_valid,
    input  in_ready, pm_we, pm_addr, pm_wdata, core_hold, done, err, word_count
  );
  modport slave (
    input  start, in_data, in_valid,
    output in_ready, pm_we, pm_addr, pm_wdata, core_hold, done, err, word_count
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: loads a framed byte stream as big-endian 16-bit words into program memory,
// verifying an XOR checksum and stalling the core while loading.
module prog_loader #(
  parameter int         ADDR_W   = 8,
  parameter logic [7:0] HDR_BYTE = 8'hA5
) (
  input logic         clk,
  input logic         rst_n,
  prog_loader_if.slave bus
);
  typedef enum logic [3:0] {IDLE, HDR, LEN, HI, LO, WRITE, CSUM, DONE, ERR} state_t;
  state_t            state_q;
  logic              in_ready_q, pm_we_q, core_hold_q, done_q, err_q;
  logic [ADDR_W-1:0] pm_addr_q;
  logic [15:0]       pm_wdata_q;
  logic [ADDR_W:0]   word_count_q, len_q, word_count_d;
  logic [7:0]        hi_q, xor_q;
  logic              acc;
  assign acc          = bus.in_valid && in_ready_q;
  assign word_count_d = word_count_q + (ADDR_W+1)'(1);
  assign bus.in_ready   = in_ready_q;
  assign bus.pm_we      = pm_we_q;
  assign bus.pm_addr    = pm_addr_q;
  assign bus.pm_wdata   = pm_wdata_q;
  assign bus.core_hold  = core_hold_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.word_count = word_count_q;
  // Outputs are set from the state being entered so every output is a plain register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      pm_we_q      <= 1'b0;
      pm_addr_q    <= '0;
      pm_wdata_q   <= '0;
      core_hold_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      word_count_q <= '0;
      len_q        <= '0;
      hi_q         <= '0;
      xor_q        <= '0;
    end else begin
      case (state_q)
        IDLE, DONE, ERR: if (bus.start) begin
          state_q      <= HDR;
          in_ready_q   <= 1'b1;
          core_hold_q  <= 1'b1;
          done_q       <= 1'b0;
          err_q        <= 1'b0;
          word_count_q <= '0;
          pm_addr_q    <= '0;
          xor_q        <= '0;
        end
        HDR: if (acc) begin
          state_q    <= (bus.in_data == HDR_BYTE) ? LEN : ERR;
          in_ready_q <= bus.in_data == HDR_BYTE;
          err_q      <= bus.in_data != HDR_BYTE;
        end
        LEN: if (acc) begin
          state_q <= HI;
          len_q   <= (bus.in_data == 8'd0) ? (ADDR_W+1)'(1) << ADDR_W : (ADDR_W+1)'(bus.in_data);
        end
        HI: if (acc) begin
          state_q <= LO;
          hi_q    <= bus.in_data;
          xor_q   <= xor_q ^ bus.in_data;
        end
        LO: if (acc) begin
          state_q    <= WRITE;
          in_ready_q <= 1'b0;
          pm_we_q    <= 1'b1;
          pm_wdata_q <= {hi_q, bus.in_data};
          xor_q      <= xor_q ^ bus.in_data;
        end
        WRITE: begin
          state_q      <= (word_count_d == len_q) ? CSUM : HI;
          in_ready_q   <= 1'b1;
          pm_we_q      <= 1'b0;
          word_count_q <= word_count_d;
          pm_addr_q    <= pm_addr_q + ADDR_W'(1);
        end
        CSUM: if (acc) begin
          state_q     <= (bus.in_data == xor_q) ? DONE : ERR;
          in_ready_q  <= 1'b0;
          done_q      <= bus.in_data == xor_q;
          err_q       <= bus.in_data != xor_q;
          core_hold_q <= bus.in_data != xor_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
